// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern of PAT_LEN bits.
// It supports overlapping or non-overlapping matching and keeps a saturating match counter.
module seq_detector_param #(
  parameter int                 PAT_LEN  = 3,
  parameter logic [PAT_LEN-1:0] PAT_INIT = 3'b101,
  parameter int                 CNT_W    = 8,
  localparam int                FILL_W   = $clog2(PAT_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_in,
  input  logic               data_valid,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               pattern_load,
  input  logic               overlap_en,
  input  logic               count_clr,
  output logic               data_out,
  output logic [CNT_W-1:0]   match_count,
  output logic [FILL_W-1:0]  state
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_LEN-1:0] pat_reg, pat_n;
  logic [PAT_LEN-1:0] history, hist_n, hist_shift;
  logic [FILL_W-1:0]  fill, fill_n, fill_inc;
  logic [CNT_W-1:0]   cnt_n;
  logic               out_n;
  logic               match;

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_reg     <= PAT_INIT;
      history     <= '0;
      fill        <= '0;
      data_out    <= 1'b0;
      match_count <= '0;
    end else begin
      pat_reg     <= pat_n;
      history     <= hist_n;
      fill        <= fill_n;
      data_out    <= out_n;
      match_count <= cnt_n;
    end
  end

  // Oldest bit lives in history[PAT_LEN-1], matching the pattern's first-received bit.
  always_comb begin
    pat_n      = pat_reg;
    hist_n     = history;
    fill_n     = fill;
    cnt_n      = match_count;
    out_n      = 1'b0;
    hist_shift = {history[PAT_LEN-2:0], data_in};
    fill_inc   = (fill == FILL_MAX) ? fill : fill + 1'b1;
    match      = data_valid && !pattern_load &&
                 (fill_inc == FILL_MAX) && (hist_shift == pat_reg);

    if (pattern_load) begin
      pat_n  = pattern;
      hist_n = '0;
      fill_n = '0;
    end else if (data_valid) begin
      hist_n = hist_shift;
      if (match) begin
        out_n  = 1'b1;
        fill_n = overlap_en ? FILL_MAX : '0;
        if (match_count != CNT_MAX) cnt_n = match_count + 1'b1;
      end else begin
        fill_n = fill_inc;
      end
    end

    // Clear overrides a same-cycle increment.
    if (count_clr) cnt_n = '0;
  end

  assign state = fill;

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector, successor to the fixed 3-bit FSM detector.
- Pattern length is a parameter.
- Pattern is runtime-loadable.
- Overlapping or non-overlapping detection is selectable.
- Input is qualified by a valid strobe.
- Keeps a saturating match counter.

Sits on a serial bit stream in front of framing/sync logic and flags each occurrence of the pattern.

Parameters:
PAT_LEN, 3, pattern length in bits (>= 2).
PAT_INIT, 3'b101, pattern value after reset (width PAT_LEN).
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous reset, active-high.
data_in  input  1  serial data bit.
data_valid  input  1  data_in is sampled only when 1.
pattern  input  PAT_LEN  new pattern; bit PAT_LEN-1 is the first bit received.
pattern_load  input  1  latch pattern into internal register.
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
count_clr  input  1  clear match counter.
data_out  output  1  one-cycle match pulse.
match_count  output  CNT_W  number of matches, saturating.
state  output  clog2(PAT_LEN+1)  fill level: valid bits held in history, 0..PAT_LEN.

Behaviour:
- Reset (highest priority), on the clk edge with reset=1:
  - pat_reg=PAT_INIT, history=0, fill=0.
  - data_out=0, match_count=0.
- Internal registers:
  - pat_reg, PAT_LEN bits.
  - history, PAT_LEN-bit shift register.
  - fill, saturating at PAT_LEN, driven on state.
- pattern_load=1 (priority over data_valid):
  - pat_reg<=pattern, history<=0, fill<=0, data_out<=0.
  - Any simultaneous data bit is discarded.
  - match_count is unchanged.
- data_valid=1, no load:
  - hist_n = {history[PAT_LEN-2:0], data_in}; history<=hist_n.
  - fill_n = min(fill+1, PAT_LEN).
  - match = (fill_n==PAT_LEN) && (hist_n==pat_reg).
- On match:
  - data_out<=1 for exactly one cycle, i.e. high the cycle after the completing bit is sampled.
  - match_count increments, saturating at 2^CNT_W-1 (no wrap).
  - overlap_en=1: fill<=PAT_LEN and history is kept, so the next valid bit can complete a new match.
  - overlap_en=0: fill<=0, so PAT_LEN fresh bits are needed before the next match.
- No match: fill<=fill_n, data_out<=0.
- data_valid=0:
  - history, fill and match_count hold.
  - data_out<=0.
  - Gaps do not break a partial sequence.
- count_clr=1: match_count<=0.
  - Clear wins over a simultaneous increment; count ends at 0.
  - data_out still pulses for that match.
- overlap_en is sampled on the cycle of the match only; changing it mid-stream is legal.
- Latency: 1 cycle from the completing valid bit to data_out.
- Max match rate is 1 per valid bit in overlap mode, 1 per PAT_LEN valid bits in non-overlap mode.
- Reset mid-sequence discards all partial progress; a match on the reset cycle is not counted.
- Implementation target: 120–250 lines; no latches; all outputs registered.

Test Plan:
1. Reset, defaults (101), overlap_en=1, valid bits 1,0,1,0,1 -> data_out pulses after bit 3 and bit 5, match_count=2, state=3 at end.
2. Same stream, overlap_en=0 -> single pulse after bit 3, match_count=1, state=2 at end.
3. Bits 1,0 valid, then 4 cycles data_valid=0, then bit 1 valid -> state holds 2 during gap; one pulse after bit 3; match_count=1.
4. pattern_load with pattern=3'b110 and data_valid=1 in same cycle -> sample discarded, state=0; then bits 1,1,0 -> pulse, match_count increments; bits 1,0,1 -> no pulse.
5. CNT_W=2, overlap_en=1, stream of 1,0,1 repeated 6 times -> match_count reaches 3 and stays 3; count_clr coincident with a match -> match_count=0, data_out=1 that cycle.
6. Reset asserted after bits 1,0 then bit 1 valid on reset cycle -> no pulse, match_count=0, state=0; subsequent 1,0,1 -> one pulse.
